// File: rtl/led_sequence_player.sv
// rtl/led_sequence_player.sv - LED sequence player with hold/gap timing and score display
//
// Plays one of three fixed LED index sequences (testcase 1..3) or shows a
// score pattern (testcase 0). Each sequence step lights one LED for
// HOLD_CYCLES clocks, separated by GAP_CYCLES all-dark clocks, and playback
// ends with a one-cycle done pulse.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      one-cycle playback request, honoured only when idle
//   abort      synchronous cancel of a playback in progress
//   testcase   sequence select, captured on an accepted start
//   score      score for testcase 0, captured on an accepted start
//   led        registered LED drive
//   busy       high whenever a playback is in progress
//   done       one-cycle pulse on normal completion
//   cur_index  LED index of the step being shown, 0 outside SHOW
//   step       zero-based number of the current step
module led_sequence_player #(
    parameter int NUM_LEDS    = 10,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int IDX_W       = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          testcase,
    input  logic [1:0]          score,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    cur_index,
    output logic [2:0]          step
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // The counter holds "clocks remaining after this one", so a state lasts
    // load+1 clocks and the counter only ever counts down to zero.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_GAP,
        S_SCORE,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_tc;

    logic [2:0]       w_next_step;
    logic [3:0]       w_next_idx;
    logic [3:0]       w_first_idx;
    logic             w_last_step;

    function automatic logic [3:0] f_seq(input logic [1:0] tc, input logic [2:0] s);
        logic [3:0] v;
        v = 4'd0;
        case (tc)
            2'd1: begin
                case (s)
                    3'd0:    v = 4'd1;
                    3'd1:    v = 4'd9;
                    3'd2:    v = 4'd4;
                    3'd3:    v = 4'd2;
                    3'd4:    v = 4'd0;
                    3'd5:    v = 4'd8;
                    3'd6:    v = 4'd7;
                    default: v = 4'd5;
                endcase
            end
            2'd2: begin
                case (s)
                    3'd0:    v = 4'd0;
                    3'd1:    v = 4'd4;
                    3'd2:    v = 4'd1;
                    3'd3:    v = 4'd3;
                    default: v = 4'd2;
                endcase
            end
            2'd3: begin
                case (s)
                    3'd0:    v = 4'd9;
                    3'd1:    v = 4'd2;
                    default: v = 4'd7;
                endcase
            end
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] f_last(input logic [1:0] tc);
        logic [2:0] v;
        case (tc)
            2'd1:    v = 3'd7;
            2'd2:    v = 3'd4;
            2'd3:    v = 3'd2;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

    function automatic logic [NUM_LEDS-1:0] f_onehot(input logic [3:0] idx);
        return NUM_LEDS'(1) << idx;
    endfunction

    function automatic logic [NUM_LEDS-1:0] f_score(input logic [1:0] sc);
        logic [9:0] v;
        case (sc)
            2'd0:    v = 10'h000;
            2'd1:    v = 10'h200;
            2'd2:    v = 10'h2AA;
            default: v = 10'h3FF;
        endcase
        return NUM_LEDS'(v);
    endfunction

    assign w_next_step = step + 3'd1;
    assign w_next_idx  = f_seq(r_tc, w_next_step);
    assign w_first_idx = f_seq(testcase, 3'd0);
    assign w_last_step = (step == f_last(r_tc));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tc      <= 2'd0;
            led       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_index <= '0;
            step      <= 3'd0;
        end else begin
            done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                led       <= '0;
                busy      <= 1'b0;
                cur_index <= '0;
                step      <= 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Abort takes priority over a simultaneous start.
                        if (start && !abort) begin
                            r_tc  <= testcase;
                            busy  <= 1'b1;
                            step  <= 3'd0;
                            r_cnt <= HOLD_LOAD;
                            if (testcase == 2'd0) begin
                                r_state <= S_SCORE;
                                led     <= f_score(score);
                            end else begin
                                r_state   <= S_SHOW;
                                led       <= f_onehot(w_first_idx);
                                cur_index <= IDX_W'(w_first_idx);
                            end
                        end
                    end
                    S_SHOW: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (w_last_step) begin
                            r_state   <= S_FINISH;
                            led       <= '0;
                            done      <= 1'b1;
                            cur_index <= '0;
                        end else if (GAP_CYCLES > 0) begin
                            r_state   <= S_GAP;
                            led       <= '0;
                            cur_index <= '0;
                            r_cnt     <= GAP_LOAD;
                        end else begin
                            step      <= w_next_step;
                            led       <= f_onehot(w_next_idx);
                            cur_index <= IDX_W'(w_next_idx);
                            r_cnt     <= HOLD_LOAD;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_state   <= S_SHOW;
                            step      <= w_next_step;
                            led       <= f_onehot(w_next_idx);
                            cur_index <= IDX_W'(w_next_idx);
                            r_cnt     <= HOLD_LOAD;
                        end
                    end
                    S_SCORE: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_state <= S_FINISH;
                            led     <= '0;
                            done    <= 1'b1;
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        step    <= 3'd0;
                        r_cnt   <= '0;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        led       <= '0;
                        busy      <= 1'b0;
                        cur_index <= '0;
                        step      <= 3'd0;
                        r_cnt     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_sequence_player.sv
// tb/tb_led_sequence_player.sv - self-checking bench for led_sequence_player
module tb_led_sequence_player;

    localparam int HOLD0 = 16;
    localparam int GAP0  = 4;
    localparam int HOLD1 = 1;
    localparam int GAP1  = 0;

    logic       clk;
    logic       reset_n;
    logic       start, start2;
    logic       abort, abort2;
    logic [1:0] testcase, testcase2;
    logic [1:0] score, score2;
    logic [9:0] led, led2;
    logic       busy, busy2;
    logic       done, done2;
    logic [3:0] cur_index, idx2;
    logic [2:0] step, step2;

    int checks = 0;
    int errors = 0;

    led_sequence_player #(.NUM_LEDS(10), .HOLD_CYCLES(HOLD0), .GAP_CYCLES(GAP0), .IDX_W(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .testcase(testcase), .score(score), .led(led), .busy(busy),
        .done(done), .cur_index(cur_index), .step(step)
    );

    led_sequence_player #(.NUM_LEDS(10), .HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAP1), .IDX_W(4)) u_dut_fast (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort2),
        .testcase(testcase2), .score(score2), .led(led2), .busy(busy2),
        .done(done2), .cur_index(idx2), .step(step2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] led;
        logic       busy;
        logic       done;
        logic [3:0] idx;
        logic [2:0] stp;
        bit         cs;
    } exp_t;

    exp_t q[$];

    int seq1[8] = '{1, 9, 4, 2, 0, 8, 7, 5};
    int seq2[5] = '{0, 4, 1, 3, 2};
    int seq3[3] = '{9, 2, 7};

    function automatic int seq_len(input int tc);
        case (tc)
            1:       return 8;
            2:       return 5;
            3:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int seq_of(input int tc, input int s);
        case (tc)
            1:       return seq1[s];
            2:       return seq2[s];
            default: return seq3[s];
        endcase
    endfunction

    function automatic logic [9:0] score_pat(input int sc);
        case (sc)
            0:       return 10'h000;
            1:       return 10'h200;
            2:       return 10'h2AA;
            default: return 10'h3FF;
        endcase
    endfunction

    function automatic int busy_len(input int tc, input int hold, input int gap);
        if (tc == 0) return hold + 1;
        return seq_len(tc) * hold + (seq_len(tc) - 1) * gap + 1;
    endfunction

    // Cycle-by-cycle expected outputs following an accepted start.
    task automatic build(input int tc, input int sc, input int hold, input int gap);
        exp_t e;
        q.delete();
        if (tc == 0) begin
            for (int h = 0; h < hold; h++) begin
                e = '{led: score_pat(sc), busy: 1'b1, done: 1'b0, idx: 4'd0, stp: 3'd0, cs: 1'b0};
                q.push_back(e);
            end
        end else begin
            for (int s = 0; s < seq_len(tc); s++) begin
                for (int h = 0; h < hold; h++) begin
                    e.led  = 10'd1 << seq_of(tc, s);
                    e.busy = 1'b1;
                    e.done = 1'b0;
                    e.idx  = 4'(seq_of(tc, s));
                    e.stp  = 3'(s);
                    e.cs   = 1'b1;
                    q.push_back(e);
                end
                if (s < seq_len(tc) - 1) begin
                    for (int g = 0; g < gap; g++) begin
                        e = '{led: 10'd0, busy: 1'b1, done: 1'b0, idx: 4'd0, stp: 3'(s), cs: 1'b1};
                        q.push_back(e);
                    end
                end
            end
        end
        e = '{led: 10'd0, busy: 1'b1, done: 1'b1, idx: 4'd0, stp: 3'd0, cs: 1'b0};
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int d, output logic [9:0] l, output logic b, output logic dn,
                          output logic [3:0] ix, output logic [2:0] st);
        if (d == 0) begin
            l = led; b = busy; dn = done; ix = cur_index; st = step;
        end else begin
            l = led2; b = busy2; dn = done2; ix = idx2; st = step2;
        end
    endtask

    task automatic drive(input int d, input bit st, input int tc, input int sc, input bit ab);
        if (d == 0) begin
            start = st; testcase = tc[1:0]; score = sc[1:0]; abort = ab;
        end else begin
            start2 = st; testcase2 = tc[1:0]; score2 = sc[1:0]; abort2 = ab;
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        logic [9:0] l; logic b, dn; logic [3:0] ix; logic [2:0] st;
        sample(d, l, b, dn, ix, st);
        chk({tag, " led"}, 32'(l), 32'd0);
        chk({tag, " busy"}, 32'(b), 32'd0);
        chk({tag, " done"}, 32'(dn), 32'd0);
        chk({tag, " idx"}, 32'(ix), 32'd0);
    endtask

    // Start a playback and compare every cycle with the model. abort_at and
    // reset_at (-1 = never) cut the playback short after that model entry.
    task automatic play(input int d, input int tc, input int sc, input bit junk,
                        input int abort_at, input int reset_at);
        logic [9:0] l; logic b, dn; logic [3:0] ix; logic [2:0] st;
        int hold, gap, bc;
        string tag;
        hold = (d == 0) ? HOLD0 : HOLD1;
        gap  = (d == 0) ? GAP0 : GAP1;
        build(tc, sc, hold, gap);
        bc = 0;
        drive(d, 1'b1, tc, sc, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < q.size(); i++) begin
            tag = $sformatf("d%0d tc%0d sc%0d i%0d", d, tc, sc, i);
            sample(d, l, b, dn, ix, st);
            chk({tag, " led"}, 32'(l), 32'(q[i].led));
            chk({tag, " busy"}, 32'(b), 32'(q[i].busy));
            chk({tag, " done"}, 32'(dn), 32'(q[i].done));
            chk({tag, " idx"}, 32'(ix), 32'(q[i].idx));
            if (q[i].cs) chk({tag, " step"}, 32'(st), 32'(q[i].stp));
            if (b) bc++;
            if (i == abort_at) begin
                drive(d, 1'b1, tc, sc, 1'b1);
                @(posedge clk); #1;
                chk_idle(d, {tag, " abort"});
                drive(d, 1'b0, tc, sc, 1'b0);
                @(posedge clk); #1;
                chk_idle(d, {tag, " post-abort"});
                return;
            end
            if (i == reset_at) begin
                #1 reset_n = 1'b0;
                #1;
                chk_idle(d, {tag, " async-reset"});
                chk({tag, " reset step"}, 32'(step), 32'd0);
                reset_n = 1'b1;
                drive(d, 1'b0, tc, sc, 1'b0);
                return;
            end
            if (junk)
                drive(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
            else
                drive(d, 1'b0, tc, sc, 1'b0);
            @(posedge clk); #1;
        end
        tag = $sformatf("d%0d tc%0d end", d, tc);
        chk_idle(d, tag);
        chk({tag, " busy cycles"}, 32'(bc), 32'(busy_len(tc, hold, gap)));
        drive(d, 1'b0, tc, sc, 1'b0);
    endtask

    initial begin
        int tc, sc, ab;
        bit jk;
        drive(0, 1'b0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0);
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk_idle(0, "reset");
        chk("reset step", 32'(step), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;

        // Start on the first edge after reset release.
        play(0, 3, 0, 1'b0, -1, -1);
        play(0, 0, 2, 1'b0, -1, -1);
        play(0, 0, 0, 1'b0, -1, -1);
        play(0, 1, 0, 1'b1, -1, -1);
        // Abort inside the second gap (entries 36..39).
        play(0, 2, 0, 1'b0, 37, -1);
        // Reset pulse while step index 3 is showing, then a fresh playback.
        play(0, 2, 0, 1'b0, -1, 65);
        play(0, 2, 0, 1'b0, -1, -1);

        // Abort and start together in IDLE.
        drive(0, 1'b1, 1, 0, 1'b1);
        @(posedge clk); #1;
        chk_idle(0, "idle abort+start");
        drive(0, 1'b0, 1, 0, 1'b0);
        @(posedge clk); #1;
        chk_idle(0, "idle abort+start next");

        play(1, 2, 0, 1'b0, -1, -1);
        play(1, 1, 0, 1'b1, -1, -1);

        for (int n = 0; n < 16; n++) begin
            tc = int'($urandom_range(0, 3));
            sc = int'($urandom_range(0, 3));
            jk = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, busy_len(tc, HOLD0, GAP0) - 1)) : -1;
            play(0, tc, sc, jk, ab, -1);
            play(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequence_player.md
LED_SEQUENCE_PLAYER -- requirements
Module: led_sequence_player

Interface
REQ-001 Parameter NUM_LEDS, default 10, LED count; SHALL be >= 10.
REQ-002 Parameter HOLD_CYCLES, default 16, clocks each step's LED stays lit; SHALL be >= 1.
REQ-003 Parameter GAP_CYCLES, default 4, all-dark clocks between steps; 0 SHALL mean no gap.
REQ-004 Parameter IDX_W, default 4, LED index width; SHALL be >= ceil(log2(NUM_LEDS)).
REQ-005 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin playback.
REQ-008 abort  input  1  synchronous cancel of playback in progress.
REQ-009 testcase  input  2  selects the sequence, sampled on accepted start.
REQ-010 score  input  2  score for case 0, sampled on accepted start.
REQ-011 led  output  NUM_LEDS  registered LED drive.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 cur_index  output  IDX_W  LED index of the current step; 0 when not in SHOW.
REQ-015 step  output  3  zero-based number of the current step.

Function
REQ-016 The states SHALL be IDLE, SHOW, GAP, SCORE and FINISH.
REQ-017 Start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-018 Sequence for testcase 3 SHALL be 9,2,7 (3 steps).
REQ-019 Sequence for testcase 2 SHALL be 0,4,1,3,2 (5 steps).
REQ-020 Sequence for testcase 1 SHALL be 1,9,4,2,0,8,7,5 (8 steps).
REQ-021 Testcase 0 SHALL enter SCORE and display a fixed pattern on led[9:0]:
  - score 0: 0x000
  - score 1: 0x200
  - score 2: 0x2AA
  - score 3: 0x3FF
  - led bits above 9: 0
REQ-022 Accepted start at edge k SHALL put the block in SHOW or SCORE from edge k, with led valid in the following cycle.
REQ-023 In SHOW, led SHALL be one-hot at the sequence entry for exactly HOLD_CYCLES clocks.
REQ-024 SHOW SHALL then go to GAP if more steps remain and GAP_CYCLES > 0.
REQ-025 SHOW SHALL go straight to the next SHOW step if more steps remain and GAP_CYCLES = 0.
REQ-026 On the last step, SHOW SHALL go to FINISH.
REQ-027 In GAP, led SHALL be all zero for exactly GAP_CYCLES clocks; step SHALL then increment and the block SHALL return to SHOW.
REQ-028 The last step SHALL NOT be followed by a gap.
REQ-029 SCORE SHALL hold its pattern for HOLD_CYCLES clocks, then go to FINISH.
REQ-030 FINISH SHALL last one cycle with led = 0 and done = 1, then return to IDLE.
REQ-031 Abort in any busy state SHALL return the block to IDLE at the next edge with led = 0 and no done pulse.
REQ-032 Abort and start in the same IDLE cycle: abort SHALL win and start SHALL be ignored.
REQ-033 The hold/gap counter SHALL be wide enough for max(HOLD_CYCLES, GAP_CYCLES).
REQ-034 The counter SHALL reload on every state entry and SHALL never wrap within a state.
REQ-035 Changes to testcase or score during playback SHALL have no effect.
REQ-036 Total busy cycles SHALL be steps*HOLD + (steps-1)*GAP + 1 for testcases 1-3, and HOLD + 1 for testcase 0.

Reset
REQ-037 reset_n low SHALL immediately force:
  - state IDLE
  - led 0, busy 0, done 0
  - cur_index 0, step 0
  - counter 0
REQ-038 Reset asserted mid-playback SHALL abandon the sequence with no done pulse.
REQ-039 After reset_n is released, the block SHALL accept start on the first rising edge.

Verification
REQ-040 Testcase 3, default parameters, start pulse -> led sequence, then one-cycle done:
  - 0x200 for 16 cycles
  - 0 for 4 cycles
  - 0x004 for 16 cycles
  - 0 for 4 cycles
  - 0x080 for 16 cycles
  - busy for 57 cycles in total
REQ-041 Testcase 0, score 2 -> led 0x2AA for 16 cycles, then done.
REQ-042 Testcase 0, score 0 -> led 0 for 16 cycles, then done.
REQ-043 Testcase 1, start repeated during step 3 and testcase changed to 2 -> all 8 steps play unchanged.
REQ-044 Testcase 2, abort during the second GAP -> IDLE next cycle, led 0, no done.
REQ-045 Testcase 2, reset_n pulsed low during step 4 -> outputs zero asynchronously, and a new start then plays from step 0.
REQ-046 GAP_CYCLES=0, HOLD_CYCLES=1, testcase 2 -> led 0x001, 0x010, 0x002, 0x008, 0x004 on consecutive cycles, then done.
